// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Merges the pipeline's ifetch port (read-only) and data port (read/write with
//   byte select) onto one physical line-memory interface. It grants one
//   requester at a time and latches that requester's command. The grant is held
//   until pmem_resp. The data port has priority. A saturating starvation counter
//   forces an ifetch grant after STARVE_MAX consecutive data grants that were
//   made while ifetch was waiting.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   if_read/if_address          ifetch line read request (held until if_resp)
//   if_rdata/if_resp            ifetch read line and 1-cycle done pulse
//   d_read/d_write/d_address    data line request (held until d_resp)
//   d_wdata/d_sel               data write line and byte enables
//   d_rdata/d_resp              data read line and 1-cycle done pulse
//   pmem_read/pmem_write        physical strobes (registered)
//   pmem_address/wdata/sel      physical command (registered)
//   pmem_rdata/pmem_resp        physical read line and done pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int LINE_W     = 128,
    parameter int SEL_W      = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_read,
    input  logic [ADDR_W-1:0] if_address,
    output logic [LINE_W-1:0] if_rdata,
    output logic              if_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    input  logic [SEL_W-1:0]  d_sel,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic [SEL_W-1:0]  pmem_sel,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IF = 2'd1,
        ST_GRANT_D  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                grant_if_s;
    logic                grant_d_s;
    logic                d_pend_s;
    logic [CNT_W-1:0]    starve_cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LINE_W-1:0]   wdata_r;
    logic [SEL_W-1:0]    sel_r;
    logic                rd_r;
    logic                wr_r;

    assign d_pend_s = d_read | d_write;

    // State register: FSM state update with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and grant decision; requests are only sampled in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        grant_if_s  = 1'b0;
        grant_d_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (d_pend_s && if_read) begin
                    // Both waiting: ifetch wins only once data has had its run.
                    if (starve_cnt_r == STARVE_LIM) begin
                        grant_if_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (d_pend_s) begin
                    grant_d_s = 1'b1;
                end else if (if_read) begin
                    grant_if_s = 1'b1;
                end else begin
                    grant_if_s = 1'b0;
                end

                if (grant_if_s) begin
                    state_nxt_s = ST_GRANT_IF;
                end else if (grant_d_s) begin
                    state_nxt_s = ST_GRANT_D;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT_IF, ST_GRANT_D: begin
                if (pmem_resp) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: responses route the physical done pulse to the granted port.
    always_comb begin
        if_resp = 1'b0;
        d_resp  = 1'b0;
        case (state_r)
            ST_GRANT_IF: if_resp = pmem_resp;
            ST_GRANT_D:  d_resp  = pmem_resp;
            default: begin
                if_resp = 1'b0;
                d_resp  = 1'b0;
            end
        endcase
    end

    // Command latch: captures the winning request so pmem_* ignore later input changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {LINE_W{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else if (grant_if_s) begin
            addr_r  <= if_address;
            wdata_r <= {LINE_W{1'b0}};
            sel_r   <= {SEL_W{1'b1}};
            rd_r    <= 1'b1;
            wr_r    <= 1'b0;
        end else if (grant_d_s) begin
            addr_r  <= d_address;
            wdata_r <= d_wdata;
            sel_r   <= d_sel;
            // Simultaneous read and write is illegal; the write takes precedence.
            rd_r    <= d_read & ~d_write;
            wr_r    <= d_write;
        end else if ((state_r != ST_IDLE) && pmem_resp) begin
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else begin
            rd_r    <= rd_r;
            wr_r    <= wr_r;
        end
    end

    // Starvation counter: counts data grants taken while ifetch is waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_d_s && if_read) begin
            if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else if (grant_if_s || grant_d_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign pmem_read    = rd_r;
    assign pmem_write   = wr_r;
    assign pmem_address = addr_r;
    assign pmem_wdata   = wdata_r;
    assign pmem_sel     = sel_r;
    assign if_rdata     = pmem_rdata;
    assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed-vector bench for mem_port_arbiter. Inputs are driven on the falling
//   edge. Outputs are sampled 1 time unit later, which is still away from the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         if_read;
    logic [11:0]  if_address;
    logic [127:0] if_rdata;
    logic         if_resp;
    logic         d_read;
    logic         d_write;
    logic [11:0]  d_address;
    logic [127:0] d_wdata;
    logic [15:0]  d_sel;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [11:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [15:0]  pmem_sel;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] W2 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;

    mem_port_arbiter #(
        .ADDR_W(12), .LINE_W(128), .SEL_W(16), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_read(if_read), .if_address(if_address), .if_rdata(if_rdata), .if_resp(if_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_sel(pmem_sel), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; pmem_resp defaults low every cycle.
    task automatic step;
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if_read    = 1'($urandom);
            if_address = 12'($urandom);
            d_read     = 1'($urandom);
            d_write    = 1'($urandom);
            d_address  = 12'($urandom);
            d_wdata    = {$urandom, $urandom, $urandom, $urandom};
            d_sel      = 16'($urandom);
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            pmem_resp  = 1'($urandom);
            #1;
            checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {pmem_read, pmem_write}); end
            checks++; if (pmem_address !== 12'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", pmem_address); end
            checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", pmem_wdata); end
            checks++; if (pmem_sel !== 16'h0000) begin errors++; $display("FAIL rst_sel got %h exp 0000", pmem_sel); end
            checks++; if ({if_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", {if_resp, d_resp}); end
        end
        step();
        if_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        if_address = 12'h000; d_address = 12'h000; d_wdata = 128'h0; d_sel = 16'h0000;
        pmem_rdata = 128'h0;
        rst_n = 1'b1;
        #1;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL rel_strobes got %b exp 00", {pmem_read, pmem_write}); end
        // A stray pmem_resp while idle must be ignored.
        step();
        pmem_resp = 1'b1;
        #1;
        checks++; if ({if_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL idle_resp got %b exp 00", {if_resp, d_resp}); end
        step();
        #1;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL idle_strobes got %b exp 00", {pmem_read, pmem_write}); end
    endtask

    task automatic test_ifetch;
        step();
        if_read = 1'b1; if_address = 12'h123;
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL t2_read c%0d got %b exp 1", c, pmem_read); end
            checks++; if (pmem_address !== 12'h123) begin errors++; $display("FAIL t2_addr got %h exp 123", pmem_address); end
            checks++; if (pmem_sel !== 16'hFFFF) begin errors++; $display("FAIL t2_sel got %h exp ffff", pmem_sel); end
            checks++; if (if_resp !== 1'b0) begin errors++; $display("FAIL t2_early_resp got %b exp 0", if_resp); end
        end
        step();
        pmem_resp = 1'b1; pmem_rdata = LINE_A5;
        #1;
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL t2_read3 got %b exp 1", pmem_read); end
        checks++; if ({if_resp, d_resp} !== 2'b10) begin errors++; $display("FAIL t2_resp got %b exp 10", {if_resp, d_resp}); end
        checks++; if (if_rdata !== LINE_A5) begin errors++; $display("FAIL t2_rdata got %h exp %h", if_rdata, LINE_A5); end
        checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL t2_wdata got %h exp 0", pmem_wdata); end
        if_read = 1'b0;
        step();
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL t2_read_off got %b exp 0", pmem_read); end
        checks++; if (if_resp !== 1'b0) begin errors++; $display("FAIL t2_single_pulse got %b exp 0", if_resp); end
    endtask

    task automatic test_priority;
        step();
        if_read = 1'b1; if_address = 12'h010;
        d_read  = 1'b1; d_address  = 12'h200;
        step();
        #1;
        checks++; if (pmem_address !== 12'h200) begin errors++; $display("FAIL t3_first_addr got %h exp 200", pmem_address); end
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL t3_first_read got %b exp 1", pmem_read); end
        step();
        pmem_resp = 1'b1;
        #1;
        checks++; if ({if_resp, d_resp} !== 2'b01) begin errors++; $display("FAIL t3_d_resp got %b exp 01", {if_resp, d_resp}); end
        d_read = 1'b0;
        step();
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL t3_idle_gap got %b exp 0", pmem_read); end
        step();
        #1;
        checks++; if (pmem_address !== 12'h010) begin errors++; $display("FAIL t3_second_addr got %h exp 010", pmem_address); end
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL t3_second_read got %b exp 1", pmem_read); end
        step();
        pmem_resp = 1'b1;
        #1;
        checks++; if ({if_resp, d_resp} !== 2'b10) begin errors++; $display("FAIL t3_if_resp got %b exp 10", {if_resp, d_resp}); end
        if_read = 1'b0;
        step();
        #1;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL t3_done got %b exp 00", {pmem_read, pmem_write}); end
    endtask

    task automatic test_write_latch;
        step();
        d_write = 1'b1; d_address = 12'h0FF; d_sel = 16'h00F0; d_wdata = W1;
        step();
        d_wdata = W2; d_sel = 16'hFFFF; d_address = 12'h3AB;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if ({pmem_write, pmem_read} !== 2'b10) begin errors++; $display("FAIL t4_strobes got %b exp 10", {pmem_write, pmem_read}); end
            checks++; if (pmem_wdata !== W1) begin errors++; $display("FAIL t4_wdata got %h exp %h", pmem_wdata, W1); end
            checks++; if (pmem_sel !== 16'h00F0) begin errors++; $display("FAIL t4_sel got %h exp 00f0", pmem_sel); end
            checks++; if (pmem_address !== 12'h0FF) begin errors++; $display("FAIL t4_addr got %h exp 0ff", pmem_address); end
            step();
        end
        pmem_resp = 1'b1;
        #1;
        checks++; if ({if_resp, d_resp} !== 2'b01) begin errors++; $display("FAIL t4_resp got %b exp 01", {if_resp, d_resp}); end
        d_write = 1'b0;
        step();
        #1;
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL t4_write_off got %b exp 0", pmem_write); end
        // Read and write together: the write wins.
        d_read = 1'b1; d_write = 1'b1; d_address = 12'h0AA;
        step();
        #1;
        checks++; if ({pmem_write, pmem_read} !== 2'b10) begin errors++; $display("FAIL t4_rw_strobes got %b exp 10", {pmem_write, pmem_read}); end
        step();
        pmem_resp = 1'b1;
        #1;
        checks++; if (d_resp !== 1'b1) begin errors++; $display("FAIL t4_rw_resp got %b exp 1", d_resp); end
        d_read = 1'b0; d_write = 1'b0;
        step();
        #1;
        checks++; if ({pmem_write, pmem_read} !== 2'b00) begin errors++; $display("FAIL t4_rw_done got %b exp 00", {pmem_write, pmem_read}); end
    endtask

    task automatic test_starvation;
        logic exp_if [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic found;
        if_read = 1'b1; if_address = 12'h010;
        d_read  = 1'b1; d_address  = 12'h200;
        for (int k = 0; k < 10; k++) begin
            found = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                step();
                #1;
                if (pmem_read) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL t5_timeout txn %0d got no strobe exp strobe", k);
            end else begin
                if (pmem_address !== (exp_if[k] ? 12'h010 : 12'h200)) begin
                    errors++; $display("FAIL t5_order txn %0d got %h exp %h", k, pmem_address, exp_if[k] ? 12'h010 : 12'h200);
                end
                step();
                pmem_resp = 1'b1;
                #1;
                checks++; if ({if_resp, d_resp} !== {exp_if[k], ~exp_if[k]}) begin errors++; $display("FAIL t5_resp txn %0d got %b exp %b", k, {if_resp, d_resp}, {exp_if[k], ~exp_if[k]}); end
                if (exp_if[k]) begin
                    checks++; if (dut.starve_cnt_r !== 3'd0) begin errors++; $display("FAIL t5_cnt_clear txn %0d got %0d exp 0", k, dut.starve_cnt_r); end
                end
            end
        end
        if_read = 1'b0; d_read = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_grant;
        step();
        d_read = 1'b1; d_address = 12'h055;
        step();
        #1;
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL t6_granted got %b exp 1", pmem_read); end
        rst_n = 1'b0;
        step();
        pmem_resp = 1'b1;
        #1;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL t6_strobes got %b exp 00", {pmem_read, pmem_write}); end
        checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL t6_no_resp got %b exp 0", d_resp); end
        checks++; if (dut.state_r !== 2'd0) begin errors++; $display("FAIL t6_state got %0d exp 0", dut.state_r); end
        d_read = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        #1;
        checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL t6_after got %b exp 00", {pmem_read, pmem_write}); end
    endtask

    initial begin
        rst_n = 1'b0; if_read = 1'b0; if_address = 12'h000;
        d_read = 1'b0; d_write = 1'b0; d_address = 12'h000; d_wdata = 128'h0; d_sel = 16'h0000;
        pmem_rdata = 128'h0; pmem_resp = 1'b0;
        test_reset();
        test_ifetch();
        test_priority();
        test_write_latch();
        test_starvation();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
